// File: rtl/knight_pkg.sv
// Shared constants and state types for the KnightsTour UART command link.
// Baud default, response codes and FSM encodings live here.
package knight_pkg;

  localparam int BAUD_DIV_DEF = 2604;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    ASM_WAIT_HI,
    ASM_WAIT_LO
  } asm_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_TRANSMIT
  } tx_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// UART byte serializer: 8N1 frame, LSB first, one bit per BAUD_DIV clocks.
// Line idles high; o_done is a level raised after the stop bit completes.
module uart_byte_tx
  import knight_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_send,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);

  localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);

  tx_state_t   r_st;
  tx_state_t   w_st_nxt;
  logic [9:0]  r_sh;
  logic [11:0] r_cnt;
  logic [3:0]  r_bits;
  logic        r_done;
  logic        w_load;
  logic        w_shift;
  logic        w_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= TX_IDLE;
    else        r_st <= w_st_nxt;
  end

  // Next state; a send request is only honoured while idle.
  always_comb begin
    w_st_nxt = r_st;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_last   = 1'b0;
    unique case (r_st)
      TX_IDLE: begin
        if (i_send) begin
          w_st_nxt = TX_TRANSMIT;
          w_load   = 1'b1;
        end
      end
      TX_TRANSMIT: begin
        if (r_cnt == 12'd0) begin
          w_shift = 1'b1;
          if (r_bits == 4'd9) begin
            w_st_nxt = TX_IDLE;
            w_last   = 1'b1;
          end
        end
      end
      default: w_st_nxt = TX_IDLE;
    endcase
  end

  // Shifter backfills ones so the line idles high once the frame is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= 10'h3FF;
      r_cnt  <= 12'd0;
      r_bits <= 4'd0;
      r_done <= 1'b0;
    end else if (w_load) begin
      r_sh   <= {1'b1, i_data, 1'b0};
      r_cnt  <= FULL;
      r_bits <= 4'd0;
      r_done <= 1'b0;
    end else if (w_shift) begin
      r_sh   <= {1'b1, r_sh[9:1]};
      r_cnt  <= FULL;
      r_bits <= r_bits + 4'd1;
      if (w_last) r_done <= 1'b1;
    end else if (r_st == TX_TRANSMIT) begin
      r_cnt  <= r_cnt - 12'd1;
    end
  end

  assign o_tx   = r_sh[0];
  assign o_done = r_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// UART command link: RX deserializer, 2-byte command assembler, TX responder.
// Optional CMD_TIMEOUT_EN drops a stale high byte after TIMEOUT_CLKS clocks.
module uart_cmd_wrapper
  import knight_pkg::*;
#(
  parameter int          BAUD_DIV     = BAUD_DIV_DEF,
  parameter logic [19:0] TIMEOUT_CLKS = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);
  localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);

  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_s3;
  logic        w_rx;
  logic        w_fall;
  logic        w_tick;

  rx_state_t   r_rx_st;
  rx_state_t   w_rx_nxt;
  logic [11:0] r_rx_cnt;
  logic [11:0] w_cnt_nxt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_rx_sh;
  logic [7:0]  w_sh_nxt;
  logic        w_rx_rdy;
  logic        w_frm_err;

  asm_state_t  r_asm;
  asm_state_t  w_asm_nxt;
  logic [7:0]  r_hi;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        w_store_hi;
  logic        w_store_cmd;
  logic        w_timeout;

  // Two-flop synchronizer plus a delay flop for start-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx   = r_rx_s2;
  assign w_fall = r_rx_s3 & ~r_rx_s2;
  assign w_tick = (r_rx_cnt == 12'd0);

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st   <= RX_IDLE;
      r_rx_cnt  <= 12'd0;
      r_bit_idx <= 3'd0;
      r_rx_sh   <= 8'd0;
    end else begin
      r_rx_st   <= w_rx_nxt;
      r_rx_cnt  <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_rx_sh   <= w_sh_nxt;
    end
  end

  // RX sequencing: half-bit start check, then centre-of-bit sampling.
  always_comb begin
    w_rx_nxt  = r_rx_st;
    w_cnt_nxt = w_tick ? 12'd0 : r_rx_cnt - 12'd1;
    w_bit_nxt = r_bit_idx;
    w_sh_nxt  = r_rx_sh;
    w_rx_rdy  = 1'b0;
    w_frm_err = 1'b0;
    unique case (r_rx_st)
      RX_IDLE: begin
        w_cnt_nxt = HALF;
        if (w_fall) w_rx_nxt = RX_START;
      end
      RX_START: begin
        if (w_tick) begin
          if (!w_rx) begin
            w_rx_nxt  = RX_DATA;
            w_cnt_nxt = FULL;
            w_bit_nxt = 3'd0;
          end else begin
            w_rx_nxt  = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_sh_nxt  = {w_rx, r_rx_sh[7:1]};
          w_cnt_nxt = FULL;
          w_bit_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          w_rx_nxt = RX_IDLE;
          if (w_rx) w_rx_rdy  = 1'b1;
          else      w_frm_err = 1'b1;
        end
      end
      default: w_rx_nxt = RX_IDLE;
    endcase
  end

`ifdef CMD_TIMEOUT_EN
  logic [19:0] r_to_cnt;

  // Gap timer: runs only while a high byte waits for its partner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 20'd0;
    end else if (r_asm != ASM_WAIT_LO || w_rx_rdy || w_frm_err) begin
      r_to_cnt <= 20'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 20'd1;
    end
  end

  assign w_timeout = (r_asm == ASM_WAIT_LO) &&
                     (r_to_cnt == TIMEOUT_CLKS - 20'd1);
`else
  assign w_timeout = 1'b0;
`endif

  // Assembler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_asm <= ASM_WAIT_HI;
    else        r_asm <= w_asm_nxt;
  end

  // Pair bytes high-then-low; errors and timeouts restart the pair.
  always_comb begin
    w_asm_nxt   = r_asm;
    w_store_hi  = 1'b0;
    w_store_cmd = 1'b0;
    unique case (r_asm)
      ASM_WAIT_HI: begin
        if (w_rx_rdy) begin
          w_asm_nxt  = ASM_WAIT_LO;
          w_store_hi = 1'b1;
        end
      end
      ASM_WAIT_LO: begin
        if (w_rx_rdy) begin
          w_asm_nxt   = ASM_WAIT_HI;
          w_store_cmd = 1'b1;
        end else if (w_frm_err || w_timeout) begin
          w_asm_nxt   = ASM_WAIT_HI;
        end
      end
      default: w_asm_nxt = ASM_WAIT_HI;
    endcase
  end

  // Command registers; a completed command beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi      <= 8'd0;
      r_cmd     <= 16'd0;
      r_cmd_rdy <= 1'b0;
    end else begin
      if (w_store_hi) begin
        r_hi <= r_rx_sh;
      end else if (r_asm == ASM_WAIT_LO && w_asm_nxt == ASM_WAIT_HI) begin
        r_hi <= 8'd0;
      end
      if (w_store_cmd) r_cmd <= {r_hi, r_rx_sh};
      if (w_store_cmd) begin
        r_cmd_rdy <= 1'b1;
      end else if (w_store_hi || clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_send (send_resp),
    .i_data (resp),
    .o_tx   (TX),
    .o_done (resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper with a shortened baud divider.
// Monitors pop expected commands and TX frames as the DUT produces them.
module tb_uart_cmd_wrapper;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        resp_sent;

  int total = 0;
  int bad = 0;
  int rst_cnt = 0;
  logic [15:0] cmd_q[$];
  logic [9:0]  tx_q[$];

  uart_cmd_wrapper #(
    .BAUD_DIV     (B),
    .TIMEOUT_CLKS (20'd400)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  always @(negedge rst_n) rst_cnt++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(posedge clk);
      #1;
    end
    RX = 1'b1;
  endtask

  task automatic clr_pulse;
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
  endtask

  // Command monitor: every rising cmd_rdy must match the next expected.
  initial begin : mon_cmd
    logic prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy && !prev) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", {16'd0, cmd}, 32'hFFFF_FFFF);
        end else begin
          e = cmd_q.pop_front();
          chk("cmd", {16'd0, cmd}, {16'd0, e});
        end
      end
      prev = cmd_rdy;
    end
  end

  // TX monitor: sample each bit mid-period; frames cut by reset are skipped.
  initial begin : mon_tx
    logic p;
    logic [9:0] got;
    logic [9:0] e;
    int r0;
    p = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && p && !TX) begin
        r0 = rst_cnt;
        repeat (B / 2 - 1) @(negedge clk);
        got[0] = TX;
        for (int i = 1; i < 10; i++) begin
          repeat (B) @(negedge clk);
          got[i] = TX;
        end
        if (rst_cnt == r0) begin
          if (tx_q.size() == 0) begin
            chk("tx_unexpected", {22'd0, got}, 32'hFFFF_FFFF);
          end else begin
            e = tx_q.pop_front();
            chk("tx_frame", {22'd0, got}, {22'd0, e});
          end
        end
      end
      p = TX;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : main
    idle(3);
    chk("rst_tx", {31'd0, TX}, 32'd1);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    rst_n = 1'b1;
    idle(2 * B);

    // calibrate command then consume it
    cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("cal_rdy", {31'd0, cmd_rdy}, 32'd1);
    clr_pulse();
    chk("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
    idle(2 * B);

    // tour command superseded by a new high byte before consumption
    cmd_q.push_back(16'h4022);
    send_byte(8'h40, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(B);
    send_byte(8'h20, 1'b1);
    chk("supersede_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("cmd_hold", {16'd0, cmd}, 32'h4022);
    cmd_q.push_back(16'h2000);
    send_byte(8'h00, 1'b1);
    clr_pulse();
    idle(2 * B);

    // response frame with an ignored mid-frame request, full duplex
    tx_q.push_back({1'b1, 8'hA5, 1'b0});
    cmd_q.push_back(16'h2000);
    fork
      begin
        resp = 8'hA5;
        send_resp = 1'b1;
        @(posedge clk);
        #1 send_resp = 1'b0;
        chk("resp_sent_clr", {31'd0, resp_sent}, 32'd0);
        repeat (3 * B - 1) @(posedge clk);
        #1 resp = 8'h5A;
        send_resp = 1'b1;
        @(posedge clk);
        #1 send_resp = 1'b0;
        resp = 8'hA5;
        repeat (7 * B - 1) @(posedge clk);
        #1 chk("resp_sent_early", {31'd0, resp_sent}, 32'd0);
        @(posedge clk);
        #1 chk("resp_sent_set", {31'd0, resp_sent}, 32'd1);
      end
      begin
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
      end
    join
    clr_pulse();
    idle(2 * B);

    // framing error on a high byte
    send_byte(8'h40, 1'b0);
    idle(B);
    cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    clr_pulse();
    idle(2 * B);

    // framing error on a low byte discards the stored high byte
    send_byte(8'h40, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(B);
    cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    clr_pulse();
    idle(2 * B);

    // one-clock glitch must not register as a byte
    RX = 1'b0;
    @(posedge clk);
    #1 RX = 1'b1;
    idle(2 * B);
    chk("glitch_rdy", {31'd0, cmd_rdy}, 32'd0);
    cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    clr_pulse();
    idle(2 * B);

    // long gap after a high byte
    send_byte(8'h40, 1'b1);
    idle(600);
`ifdef CMD_TIMEOUT_EN
    cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
`else
    cmd_q.push_back(16'h4022);
    send_byte(8'h22, 1'b1);
`endif
    clr_pulse();
    idle(2 * B);

    // ack response
    tx_q.push_back({1'b1, 8'h5A, 1'b0});
    resp = 8'h5A;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    idle(11 * B);
    chk("ack_sent", {31'd0, resp_sent}, 32'd1);

    // reset in the middle of RX and TX frames
    cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    resp = 8'hA5;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    fork
      send_byte(8'h40, 1'b1);
      begin
        idle(4 * B);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, TX}, 32'd1);
        chk("mid_rst_cmd", {16'd0, cmd}, 32'd0);
        chk("mid_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("mid_rst_resp_sent", {31'd0, resp_sent}, 32'd0);
      end
    join
    idle(2);
    rst_n = 1'b1;
    idle(2 * B);
    cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(4 * B);

    chk("cmd_q_empty", cmd_q.size(), 32'd0);
    chk("tx_q_empty", tx_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Neighbouring stage directly downstream of the remote command link, upstream of the tour/command FSMs inside the KnightsTour top level.
- Receives two UART bytes from the RX pin and assembles them into a 16-bit command, high byte first; presents it with a cmd_rdy/clr_cmd_rdy handshake.
- Serializes 8-bit responses (e.g. 8'hA5 done, 8'h5A in-tour ack) back out on TX.
- Contains the RX deserializer, the byte-assembly FSM and the TX serializer.

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); 12-bit counter width is sufficient.
- TIMEOUT_CLKS, 20'd1_000_000, maximum gap between high and low byte (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  serial in, idle high, asynchronous to clk.
- TX  output  1  serial out, idle high.
- cmd  output  16  assembled command {high byte, low byte}.
- cmd_rdy  output  1  level: cmd valid and unconsumed.
- clr_cmd_rdy  input  1  consumer pulse: clears cmd_rdy.
- resp  input  8  response byte, sampled on send_resp.
- send_resp  input  1  pulse: start transmitting resp.
- resp_sent  output  1  level: last response fully shifted out.

Behaviour:
- Reset: TX=1, cmd=0, cmd_rdy=0, resp_sent=0. The RX double-flop synchronizer is preset to 1. All FSMs reset to IDLE.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling edge on the synchronized RX goes to START; the baud counter loads BAUD_DIV/2.
  - START: at the half-bit point, re-sample RX. If 0, go to DATA. If 1, it was a glitch; return to IDLE.
  - DATA: sample 8 bits LSB-first, one every BAUD_DIV clocks.
  - STOP: sample the stop bit. If 1, byte is valid and asserts a 1-clock rx_rdy. If 0, framing error: byte is discarded.
- Assembler FSM states: WAIT_HI, WAIT_LO.
  - WAIT_HI + rx_rdy: store the high byte and go to WAIT_LO. cmd_rdy clears on entering WAIT_LO, so a new command supersedes an unconsumed one.
  - WAIT_LO + rx_rdy: cmd <= {high, rx_byte}, cmd_rdy <= 1 on the following clock, return to WAIT_HI.
  - Framing error in either state returns the FSM to WAIT_HI and discards any stored high byte.
- cmd latency: cmd_rdy rises 1 clock after the low byte's stop-bit sample.
- cmd stability: cmd holds its value until the next complete command.
- clr_cmd_rdy clears cmd_rdy on the next clock. If it coincides with cmd_rdy being set, the set wins.
- TX FSM states: IDLE, TRANSMIT.
  - send_resp in IDLE loads the frame {1, resp, 0} into a 10-bit shifter, clears resp_sent, and shifts one bit every BAUD_DIV clocks.
  - After the 10th bit period, return to IDLE; TX=1 and resp_sent=1.
  - send_resp while in TRANSMIT is ignored; the frame in progress is not corrupted.
- RX and TX are fully independent and full-duplex.
- Reset mid-frame aborts immediately to reset values. There is no partial output; a half-received command is lost.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A 20-bit counter runs while in WAIT_LO and resets on every byte.
  - Reaching TIMEOUT_CLKS discards the high byte and returns to WAIT_HI; cmd and cmd_rdy are unchanged.
  - A low byte arriving after the timeout is treated as a new high byte.
- Undefined: no counter; WAIT_LO waits indefinitely.

Decomposition:
- Shared package (knight_pkg): BAUD_DIV default constant; response constants RESP_DONE=8'hA5 and RESP_ACK=8'h5A; enum typedefs rx_state_t, asm_state_t, tx_state_t.
- One natural sub-module: uart_byte_tx, containing the TX shifter and baud counter.
- RX and assembly stay in the top of this block.

Test Plan:
- Reset checks: assert rst_n=0 mid-frame -> TX=1, cmd=0, cmd_rdy=0, resp_sent=0 within 1 clock of reset assertion.
- Calibrate command: serial bytes 8'h20, 8'h00 -> cmd=16'h2000, cmd_rdy=1 one clock after the 2nd stop bit. clr_cmd_rdy pulse -> cmd_rdy=0 next clock.
- Tour command: bytes 8'h40, 8'h22 -> cmd=16'h4022. A new high byte 8'h20 before clr -> cmd_rdy drops once WAIT_LO is entered, and cmd stays 16'h4022 until the next complete command.
- Response: send_resp with resp=8'hA5 -> TX waveform 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing; resp_sent=1 after 10*BAUD_DIV clocks. A second send_resp mid-frame is ignored.
- Error cases: a stop bit forced to 0 on the high byte -> no cmd_rdy, and the next valid pair 8'h20, 8'h00 yields 16'h2000. A 1-clock RX glitch -> no byte received.
- CMD_TIMEOUT_EN (with the TIMEOUT_CLKS parameter reduced in the bench): high byte 8'h40, a gap longer than TIMEOUT_CLKS, then bytes 8'h20, 8'h00 -> cmd=16'h2000, not 16'h4020.
